// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register-file write port between writeback and a buffered aux requester.
// Writeback wins by default; a starvation counter forces a one-cycle stall so aux entries drain.
module regfile_write_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clkIn,
  input  logic        resetIn,
  input  logic        wbWriteIn,
  input  logic [4:0]  wbRdIn,
  input  logic [31:0] wbDataIn,
  input  logic        auxValidIn,
  input  logic [4:0]  auxRdIn,
  input  logic [31:0] auxDataIn,
  output logic        auxReadyOut,
  output logic        stallOut,
  output logic [4:0]  rdOut,
  output logic [31:0] dataOut,
  output logic        writeOut,
  output logic [31:0] pendingOut,
  output logic        errOut
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SW    = $clog2(STARVE_LIMIT + 1);

  logic [4:0]       fifo_rd_q   [DEPTH];
  logic [31:0]      fifo_data_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic             write_q, write_d;
  logic [4:0]       rd_q, rd_d;
  logic [31:0]      data_q, data_d;
  logic             err_q, err_d;

  logic             empty, full, push, pop;
  logic             grant_fifo, grant_wb;
  logic [4:0]       gnt_rd;
  logic [31:0]      gnt_data;
  logic [PTR_W-1:0] idx;
  logic [31:0]      pend;

  assign empty       = (count_q == '0);
  assign full        = (count_q == CNT_W'(DEPTH));
  assign auxReadyOut = !full;
  assign stallOut    = (starve_q == SW'(STARVE_LIMIT)) && !empty;
  assign push        = auxValidIn && !full;
  assign pop         = grant_fifo;

  always_comb begin
    grant_fifo = 1'b0;
    grant_wb   = 1'b0;
    if (stallOut)        grant_fifo = 1'b1;
    else if (wbWriteIn)  grant_wb   = 1'b1;
    else if (!empty)     grant_fifo = 1'b1;
    gnt_rd   = grant_fifo ? fifo_rd_q[rd_ptr_q]   : wbRdIn;
    gnt_data = grant_fifo ? fifo_data_q[rd_ptr_q] : wbDataIn;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    starve_d = starve_q;
    write_d  = 1'b0;
    rd_d     = rd_q;
    data_d   = data_q;
    err_d    = err_q || (stallOut && wbWriteIn);
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
    // Only WB grants made while aux work is waiting count toward starvation.
    if (empty || grant_fifo)
      starve_d = '0;
    else if (grant_wb && starve_q != SW'(STARVE_LIMIT))
      starve_d = starve_q + SW'(1);
    if (grant_fifo || grant_wb) begin
      rd_d    = gnt_rd;
      data_d  = gnt_data;
      write_d = (gnt_rd != 5'd0);
    end
  end

  always_comb begin
    pend = '0;
    idx  = rd_ptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PTR_W'(i);
      if (CNT_W'(i) < count_q && fifo_rd_q[idx] != 5'd0)
        pend[fifo_rd_q[idx]] = 1'b1;
    end
  end

  assign pendingOut = pend;

  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      write_q  <= 1'b0;
      rd_q     <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      write_q  <= write_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
      err_q    <= err_d;
    end
  end

  // Payload storage needs no reset: validity is tracked by count/pointers.
  always_ff @(posedge clkIn) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= auxRdIn;
      fifo_data_q[wr_ptr_q] <= auxDataIn;
    end
  end

  assign writeOut = write_q;
  assign rdOut    = rd_q;
  assign dataOut  = data_q;
  assign errOut   = err_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: vector table plus hand-written starvation/reset sequences.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        av;
  logic [4:0]  a_rd;
  logic [31:0] a_data;
  logic        ready, stall, wr, err;
  logic [4:0]  rd;
  logic [31:0] data, pend;

  int n_chk  = 0;
  int n_fail = 0;

  regfile_write_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clkIn(clk), .resetIn(rst_n),
    .wbWriteIn(wb), .wbRdIn(wb_rd), .wbDataIn(wb_data),
    .auxValidIn(av), .auxRdIn(a_rd), .auxDataIn(a_data),
    .auxReadyOut(ready), .stallOut(stall),
    .rdOut(rd), .dataOut(data), .writeOut(wr),
    .pendingOut(pend), .errOut(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wb;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        av;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        e_wr;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic [31:0] e_pend;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [4:0] wr_, input logic [31:0] wd,
                       input logic v, input logic [4:0] ar, input logic [31:0] ad);
    wb = w; wb_rd = wr_; wb_data = wd; av = v; a_rd = ar; a_data = ad;
  endtask

  initial begin
    // wb wbrd wbdata av ard adata | wr rd data pend
    tbl[0]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  32'h0,        32'h0};
    tbl[1]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b1, 5'd5,  32'hDEADBEEF, 32'h0};
    tbl[2]  = '{1'b1, 5'd0,  32'h12345678, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  32'h12345678, 32'h0};
    tbl[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  32'h12345678, 32'h0};
    tbl[4]  = '{1'b1, 5'd31, 32'hA5A5A5A5, 1'b0, 5'd0, 32'h0,  1'b1, 5'd31, 32'hA5A5A5A5, 32'h0};
    tbl[5]  = '{1'b1, 5'd3,  32'h33,       1'b1, 5'd7, 32'h11, 1'b1, 5'd3,  32'h33,       32'h80};
    tbl[6]  = '{1'b1, 5'd4,  32'h44,       1'b1, 5'd9, 32'h22, 1'b1, 5'd4,  32'h44,       32'h280};
    tbl[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd7,  32'h11,       32'h200};
    tbl[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd9,  32'h22,       32'h0};
    tbl[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd9,  32'h22,       32'h0};
    tbl[10] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 32'h55, 1'b0, 5'd9,  32'h22,       32'h0};
    tbl[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  32'h55,       32'h0};

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    step(); step();
    chk("rst_write", 32'(wr), 32'd0);
    chk("rst_rd", 32'(rd), 32'd0);
    chk("rst_data", data, 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_pend", pend, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].wb, tbl[i].wb_rd, tbl[i].wb_data, tbl[i].av, tbl[i].a_rd, tbl[i].a_data);
      step();
      chk($sformatf("v%0d_write", i), 32'(wr), 32'(tbl[i].e_wr));
      chk($sformatf("v%0d_rd", i), 32'(rd), 32'(tbl[i].e_rd));
      chk($sformatf("v%0d_data", i), data, tbl[i].e_data);
      chk($sformatf("v%0d_pend", i), pend, tbl[i].e_pend);
      chk($sformatf("v%0d_ready", i), 32'(ready), 32'd1);
      chk($sformatf("v%0d_stall", i), 32'(stall), 32'd0);
    end

    // Fill the FIFO while WB writes every cycle.
    for (int k = 0; k < 4; k++) begin
      drive(1, 5'(10 + k), 32'(32'h1000 + k), 1, 5'(20 + k), 32'(32'h100 + k));
      step();
      chk($sformatf("fill%0d_write", k), 32'(wr), 32'd1);
      chk($sformatf("fill%0d_rd", k), 32'(rd), 32'(10 + k));
      chk($sformatf("fill%0d_stall", k), 32'(stall), 32'd0);
    end
    chk("full_ready", 32'(ready), 32'd0);
    chk("full_pend", pend, 32'h00F00000);

    // Fifth aux request held while full; starvation builds to the limit.
    drive(1, 5'd1, 32'hAAAA0001, 1, 5'd24, 32'h104);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("starve%0d_stall", i), 32'(stall), (i == 4) ? 32'd1 : 32'd0);
      chk($sformatf("starve%0d_ready", i), 32'(ready), 32'd0);
      chk($sformatf("starve%0d_pend", i), pend, 32'h00F00000);
    end

    // Pipeline honours the stall: head entry written, held request not yet taken.
    drive(0, 5'd0, 32'h0, 1, 5'd24, 32'h104);
    step();
    chk("drain_write", 32'(wr), 32'd1);
    chk("drain_rd", 32'(rd), 32'd20);
    chk("drain_data", data, 32'h100);
    chk("drain_stall", 32'(stall), 32'd0);
    chk("drain_ready", 32'(ready), 32'd1);
    chk("drain_pend", pend, 32'h00E00000);
    chk("drain_err", 32'(err), 32'd0);

    drive(1, 5'd2, 32'hBBBB0002, 1, 5'd24, 32'h104);
    step();
    chk("enq5_pend", pend, 32'h01E00000);
    chk("enq5_ready", 32'(ready), 32'd0);
    chk("enq5_rd", 32'(rd), 32'd2);
    chk("enq5_stall", 32'(stall), 32'd0);

    drive(1, 5'd2, 32'hBBBB0002, 0, 5'd0, 32'h0);
    for (int i = 0; i < 7; i++) begin
      step();
      chk($sformatf("starve2_%0d_stall", i), 32'(stall), (i == 6) ? 32'd1 : 32'd0);
    end

    // WB presented during the stall: discarded, error latched.
    drive(1, 5'd6, 32'h00000BAD, 0, 5'd0, 32'h0);
    step();
    chk("viol_err", 32'(err), 32'd1);
    chk("viol_write", 32'(wr), 32'd1);
    chk("viol_rd", 32'(rd), 32'd21);
    chk("viol_data", data, 32'h101);
    chk("viol_stall", 32'(stall), 32'd0);

    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    step();
    chk("sticky_err", 32'(err), 32'd1);
    chk("after_rd", 32'(rd), 32'd22);
    chk("after_pend", pend, 32'h01800000);

    drive(1, 5'd8, 32'h88, 1, 5'd25, 32'h105);
    step();
    chk("pre_rst_write", 32'(wr), 32'd1);
    chk("pre_rst_rd", 32'(rd), 32'd8);
    chk("pre_rst_pend", pend, 32'h03800000);

    // Asynchronous reset mid-cycle.
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_write", 32'(wr), 32'd0);
    chk("arst_pend", pend, 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    chk("arst_ready", 32'(ready), 32'd1);
    chk("arst_stall", 32'(stall), 32'd0);
    chk("arst_rd", 32'(rd), 32'd0);
    #3;
    rst_n = 1'b1;
    step();
    chk("post_rst_write", 32'(wr), 32'd0);
    chk("post_rst_pend", pend, 32'd0);
    chk("post_rst_ready", 32'(ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
